memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_if.sv | 40 ++++
 rtl/memory_access.sv | 104 ++++++++++
 tb/tb_memory_access.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
// Execute-side inputs and WriteBack-side outputs of the memory-access stage.
// The Execute/testbench side uses the master modport; the stage itself uses slave.
interface memory_access_if;
   logic        STALL;
   logic        IN_VALID;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic        BRANCH;
   logic        MEM_TO_REG;
   logic        REG_WRITE;
   logic [31:0] ALU_RESULT;
   logic [31:0] WRITE_DATA;
   logic [31:0] BRANCH_TARGET;
   logic        ZERO;
   logic [4:0]  WRITE_REGISTER;

   logic        PC_SRC;
   logic [31:0] PC_TARGET;
   logic        WB_VALID;
   logic        WB_REG_WRITE;
   logic        WB_MEM_TO_REG;
   logic [31:0] WB_READ_DATA;
   logic [31:0] WB_ALU_RESULT;
   logic [4:0]  WB_WRITE_REGISTER;
   logic        ADDR_ERROR;

   modport master (
      output STALL, IN_VALID, MEM_READ, MEM_WRITE, BRANCH, MEM_TO_REG, REG_WRITE,
             ALU_RESULT, WRITE_DATA, BRANCH_TARGET, ZERO, WRITE_REGISTER,
      input  PC_SRC, PC_TARGET, WB_VALID, WB_REG_WRITE, WB_MEM_TO_REG,
             WB_READ_DATA, WB_ALU_RESULT, WB_WRITE_REGISTER, ADDR_ERROR
   );

   modport slave (
      input  STALL, IN_VALID, MEM_READ, MEM_WRITE, BRANCH, MEM_TO_REG, REG_WRITE,
             ALU_RESULT, WRITE_DATA, BRANCH_TARGET, ZERO, WRITE_REGISTER,
      output PC_SRC, PC_TARGET, WB_VALID, WB_REG_WRITE, WB_MEM_TO_REG,
             WB_READ_DATA, WB_ALU_RESULT, WB_WRITE_REGISTER, ADDR_ERROR
   );
endinterface

// File: rtl/memory_access.sv
// Pipeline memory-access stage: EX/MEM and MEM/WB registers around a 32-bit
// word-addressed data memory, with branch resolution and misalignment detection.
module memory_access #(
   parameter int ADDR_BITS = 8
) (
   input logic             CLK,
   input logic             RESET_N,
   memory_access_if.slave  bus
);

   typedef struct packed {
      logic        valid;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        mem_to_reg;
      logic        reg_write;
      logic        zero;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [31:0] branch_target;
      logic [4:0]  write_register;
   } ex_mem_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_to_reg;
      logic        addr_error;
      logic [31:0] read_data;
      logic [31:0] alu_result;
      logic [4:0]  write_register;
   } mem_wb_t;

   ex_mem_t ex_mem;
   mem_wb_t mem_wb;

   logic [31:0]          mem [0:(1 << ADDR_BITS) - 1];
   logic [ADDR_BITS-1:0] word_index;
   logic                 pc_src;
   logic                 misaligned;
   logic                 store_en;
   logic [31:0]          load_data;

   // Upper address bits are dropped, so addresses wrap modulo the depth.
   assign word_index = ex_mem.alu_result[ADDR_BITS+1:2];

   always_comb begin
      pc_src     = ex_mem.valid & ex_mem.branch & ex_mem.zero;
      misaligned = ex_mem.valid & (ex_mem.mem_read | ex_mem.mem_write)
                   & (ex_mem.alu_result[1:0] != 2'b00);
      store_en   = ex_mem.valid & ex_mem.mem_write & ~misaligned & ~bus.STALL;
      load_data  = (ex_mem.valid && ex_mem.mem_read) ? mem[word_index] : '0;
   end

   // NOTE: state registers use non-blocking assignments so every stage samples
   // the pre-edge value of the stage before it.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ex_mem <= '0;
         mem_wb <= '0;
      end else if (!bus.STALL) begin
         ex_mem.valid          <= bus.IN_VALID & ~pc_src;
         ex_mem.mem_read       <= bus.MEM_READ;
         ex_mem.mem_write      <= bus.MEM_WRITE;
         ex_mem.branch         <= bus.BRANCH;
         ex_mem.mem_to_reg     <= bus.MEM_TO_REG;
         ex_mem.reg_write      <= bus.REG_WRITE;
         ex_mem.zero           <= bus.ZERO;
         ex_mem.alu_result     <= bus.ALU_RESULT;
         ex_mem.write_data     <= bus.WRITE_DATA;
         ex_mem.branch_target  <= bus.BRANCH_TARGET;
         ex_mem.write_register <= bus.WRITE_REGISTER;

         mem_wb.valid          <= ex_mem.valid;
         mem_wb.reg_write      <= ex_mem.reg_write & ~misaligned;
         mem_wb.mem_to_reg     <= ex_mem.mem_to_reg;
         mem_wb.addr_error     <= misaligned;
         mem_wb.read_data      <= load_data;
         mem_wb.alu_result     <= ex_mem.alu_result;
         mem_wb.write_register <= ex_mem.write_register;
      end
   end

   // NOTE: the memory array has no reset; its contents survive RESET_N and it
   // maps onto plain RAM. Read-before-write falls out of the async read above.
   always_ff @(posedge CLK) begin
      if (store_en) begin
         mem[word_index] <= ex_mem.write_data;
      end
   end

   assign bus.PC_SRC            = pc_src;
   assign bus.PC_TARGET         = ex_mem.branch_target;
   assign bus.WB_VALID          = mem_wb.valid;
   assign bus.WB_REG_WRITE      = mem_wb.reg_write;
   assign bus.WB_MEM_TO_REG     = mem_wb.mem_to_reg;
   assign bus.WB_READ_DATA      = mem_wb.read_data;
   assign bus.WB_ALU_RESULT     = mem_wb.alu_result;
   assign bus.WB_WRITE_REGISTER = mem_wb.write_register;
   // The error is masked while stalled because the held entry is not retiring.
   assign bus.ADDR_ERROR        = mem_wb.addr_error & ~bus.STALL;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: scoreboard of issued instructions,
// retired against a reference memory model, plus directed feature scenarios.
module tb_memory_access;

   typedef struct {
      logic        valid, rd, wr, br, m2r, rw, zero;
      logic [31:0] alu, wd, bt;
      logic [4:0]  wreg;
   } ex_t;

   typedef struct {
      logic        valid, rw, m2r, err;
      logic [31:0] rdata, alu;
      logic [4:0]  wreg;
   } wb_t;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;
   int   total = 0;
   int   bad = 0;

   memory_access_if bus ();

   memory_access #(.ADDR_BITS(8)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   ex_t         sbq[$];
   wb_t         exp_wb;
   logic        prev_taken;
   logic        exp_pc;
   logic [31:0] exp_tgt;
   logic [31:0] mmem [256];

   function automatic ex_t op(input logic v, rd, wr, br, m2r, rw, z,
                              input logic [31:0] alu, wd, bt, input logic [4:0] wreg);
      ex_t e;
      e.valid = v; e.rd = rd; e.wr = wr; e.br = br; e.m2r = m2r; e.rw = rw; e.zero = z;
      e.alu = alu; e.wd = wd; e.bt = bt; e.wreg = wreg;
      return e;
   endfunction

   function automatic ex_t bubble();
      return op(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
   endfunction

   function automatic ex_t store(input logic [31:0] a, input logic [31:0] d);
      return op(1, 0, 1, 0, 0, 0, 0, a, d, 32'h0, 5'd0);
   endfunction

   function automatic ex_t load(input logic [31:0] a, input logic [4:0] r);
      return op(1, 1, 0, 0, 1, 1, 0, a, 32'h0, 32'h0, r);
   endfunction

   task automatic model_reset();
      sbq.delete();
      prev_taken = 1'b0;
      exp_wb     = '{default: '0};
      exp_pc     = 1'b0;
      exp_tgt    = 32'h0;
   endtask

   // Reference behaviour of one entry leaving EX/MEM.
   task automatic retire(input ex_t e);
      logic v, mis;
      v   = e.valid & ~prev_taken;
      mis = v & (e.rd | e.wr) & (e.alu[1:0] != 2'b00);
      exp_wb.valid = v;
      exp_wb.rw    = e.rw & ~mis;
      exp_wb.m2r   = e.m2r;
      exp_wb.err   = mis;
      exp_wb.alu   = e.alu;
      exp_wb.wreg  = e.wreg;
      exp_wb.rdata = (v & e.rd) ? mmem[e.alu[9:2]] : 32'h0;
      if (v & e.wr & ~mis) mmem[e.alu[9:2]] = e.wd;
      prev_taken = v & e.br & e.zero;
   endtask

   // Drive one cycle, advance the scoreboard, compare at the falling edge.
   task automatic step(input ex_t e, input logic stall);
      ex_t em;
      bus.STALL = stall;         bus.IN_VALID = e.valid;
      bus.MEM_READ = e.rd;       bus.MEM_WRITE = e.wr;
      bus.BRANCH = e.br;         bus.MEM_TO_REG = e.m2r;
      bus.REG_WRITE = e.rw;      bus.ZERO = e.zero;
      bus.ALU_RESULT = e.alu;    bus.WRITE_DATA = e.wd;
      bus.BRANCH_TARGET = e.bt;  bus.WRITE_REGISTER = e.wreg;
      @(posedge CLK);
      if (!stall) begin
         sbq.push_back(e);
         if (sbq.size() >= 2) retire(sbq.pop_front());
         else exp_wb = '{default: '0};
      end
      if (sbq.size() != 0) begin
         em      = sbq[sbq.size()-1];
         exp_pc  = em.valid & ~prev_taken & em.br & em.zero;
         exp_tgt = em.bt;
      end
      @(negedge CLK);
      total++; if (bus.WB_VALID !== exp_wb.valid) begin bad++;
         $display("FAIL sb_wb_valid got=%b exp=%b t=%0t", bus.WB_VALID, exp_wb.valid, $time); end
      total++; if (bus.WB_REG_WRITE !== exp_wb.rw) begin bad++;
         $display("FAIL sb_wb_reg_write got=%b exp=%b t=%0t", bus.WB_REG_WRITE, exp_wb.rw, $time); end
      total++; if (bus.WB_MEM_TO_REG !== exp_wb.m2r) begin bad++;
         $display("FAIL sb_wb_mem_to_reg got=%b exp=%b t=%0t", bus.WB_MEM_TO_REG, exp_wb.m2r, $time); end
      total++; if (bus.WB_READ_DATA !== exp_wb.rdata) begin bad++;
         $display("FAIL sb_wb_read_data got=%h exp=%h t=%0t", bus.WB_READ_DATA, exp_wb.rdata, $time); end
      total++; if (bus.WB_ALU_RESULT !== exp_wb.alu) begin bad++;
         $display("FAIL sb_wb_alu_result got=%h exp=%h t=%0t", bus.WB_ALU_RESULT, exp_wb.alu, $time); end
      total++; if (bus.WB_WRITE_REGISTER !== exp_wb.wreg) begin bad++;
         $display("FAIL sb_wb_write_register got=%0d exp=%0d t=%0t", bus.WB_WRITE_REGISTER, exp_wb.wreg, $time); end
      total++; if (bus.ADDR_ERROR !== (exp_wb.err & ~stall)) begin bad++;
         $display("FAIL sb_addr_error got=%b exp=%b t=%0t", bus.ADDR_ERROR, exp_wb.err & ~stall, $time); end
      total++; if (bus.PC_SRC !== exp_pc) begin bad++;
         $display("FAIL sb_pc_src got=%b exp=%b t=%0t", bus.PC_SRC, exp_pc, $time); end
      total++; if (bus.PC_TARGET !== exp_tgt) begin bad++;
         $display("FAIL sb_pc_target got=%h exp=%h t=%0t", bus.PC_TARGET, exp_tgt, $time); end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      bus.STALL = 1'b0; bus.IN_VALID = 1'b1; bus.MEM_READ = 1'b1; bus.MEM_WRITE = 1'b0;
      bus.BRANCH = 1'b1; bus.MEM_TO_REG = 1'b1; bus.REG_WRITE = 1'b1; bus.ZERO = 1'b1;
      bus.ALU_RESULT = 32'h13; bus.WRITE_DATA = 32'h1; bus.BRANCH_TARGET = 32'h44;
      bus.WRITE_REGISTER = 5'd9;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      total++; if ({bus.PC_SRC, bus.WB_VALID, bus.WB_REG_WRITE, bus.WB_MEM_TO_REG, bus.ADDR_ERROR} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b exp=00000",
                         {bus.PC_SRC, bus.WB_VALID, bus.WB_REG_WRITE, bus.WB_MEM_TO_REG, bus.ADDR_ERROR}); end
      total++; if (bus.PC_TARGET !== 32'h0) begin bad++;
         $display("FAIL reset_pc_target got=%h exp=0", bus.PC_TARGET); end
      total++; if ({bus.WB_READ_DATA, bus.WB_ALU_RESULT, bus.WB_WRITE_REGISTER} !== 69'h0) begin bad++;
         $display("FAIL reset_wb_data got=%h/%h/%0d exp=0/0/0",
                  bus.WB_READ_DATA, bus.WB_ALU_RESULT, bus.WB_WRITE_REGISTER); end
      RESET_N = 1'b1;
      model_reset();
   endtask

   task automatic test_store_load();
      step(store(32'h10, 32'hDEADBEEF), 1'b0);
      step(load(32'h10, 5'd5), 1'b0);
      step(bubble(), 1'b0);
      total++; if (bus.WB_READ_DATA !== 32'hDEADBEEF || bus.WB_WRITE_REGISTER !== 5'd5 || bus.WB_REG_WRITE !== 1'b1) begin
         bad++; $display("FAIL store_load got=%h/%0d/%b exp=deadbeef/5/1",
                         bus.WB_READ_DATA, bus.WB_WRITE_REGISTER, bus.WB_REG_WRITE); end
   endtask

   task automatic test_branch();
      step(store(32'h30, 32'h0BADF00D), 1'b0);
      step(op(1, 0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h40, 5'd0), 1'b0);
      total++; if (bus.PC_SRC !== 1'b1 || bus.PC_TARGET !== 32'h40) begin bad++;
         $display("FAIL branch_taken got=%b/%h exp=1/00000040", bus.PC_SRC, bus.PC_TARGET); end
      step(op(1, 0, 1, 0, 0, 1, 0, 32'h30, 32'hFFFFFFFF, 32'h0, 5'd2), 1'b0);
      step(load(32'h30, 5'd3), 1'b0);
      total++; if (bus.WB_VALID !== 1'b0) begin bad++;
         $display("FAIL branch_squash got=%b exp=0", bus.WB_VALID); end
      step(bubble(), 1'b0);
      total++; if (bus.WB_READ_DATA !== 32'h0BADF00D) begin bad++;
         $display("FAIL squash_no_store got=%h exp=0badf00d", bus.WB_READ_DATA); end
      step(op(1, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h80, 5'd0), 1'b0);
      total++; if (bus.PC_SRC !== 1'b0) begin bad++;
         $display("FAIL branch_not_taken got=%b exp=0", bus.PC_SRC); end
      step(bubble(), 1'b0);
   endtask

   task automatic test_misaligned();
      step(op(1, 0, 1, 0, 0, 1, 0, 32'h13, 32'h99999999, 32'h0, 5'd9), 1'b0);
      step(bubble(), 1'b0);
      total++; if (bus.ADDR_ERROR !== 1'b1 || bus.WB_REG_WRITE !== 1'b0) begin bad++;
         $display("FAIL misaligned_flag got=%b/%b exp=1/0", bus.ADDR_ERROR, bus.WB_REG_WRITE); end
      step(load(32'h10, 5'd6), 1'b0);
      total++; if (bus.ADDR_ERROR !== 1'b0) begin bad++;
         $display("FAIL misaligned_pulse got=%b exp=0", bus.ADDR_ERROR); end
      step(bubble(), 1'b0);
      total++; if (bus.WB_READ_DATA !== 32'hDEADBEEF) begin bad++;
         $display("FAIL misaligned_no_store got=%h exp=deadbeef", bus.WB_READ_DATA); end
   endtask

   task automatic test_wrap();
      step(store(32'h400, 32'hCAFEF00D), 1'b0);
      step(load(32'h000, 5'd1), 1'b0);
      step(bubble(), 1'b0);
      total++; if (bus.WB_READ_DATA !== 32'hCAFEF00D) begin bad++;
         $display("FAIL addr_wrap got=%h exp=cafef00d", bus.WB_READ_DATA); end
   endtask

   task automatic test_read_write();
      step(op(1, 1, 1, 0, 1, 1, 0, 32'h10, 32'h11112222, 32'h0, 5'd8), 1'b0);
      step(load(32'h10, 5'd8), 1'b0);
      total++; if (bus.WB_READ_DATA !== 32'hDEADBEEF) begin bad++;
         $display("FAIL rmw_old_data got=%h exp=deadbeef", bus.WB_READ_DATA); end
      step(bubble(), 1'b0);
      total++; if (bus.WB_READ_DATA !== 32'h11112222) begin bad++;
         $display("FAIL rmw_new_data got=%h exp=11112222", bus.WB_READ_DATA); end
   endtask

   task automatic test_stall();
      step(store(32'h21, 32'h77777777), 1'b0);
      step(store(32'h20, 32'hA5A5A5A5), 1'b0);
      total++; if (bus.ADDR_ERROR !== 1'b1) begin bad++;
         $display("FAIL stall_pre_error got=%b exp=1", bus.ADDR_ERROR); end
      for (int i = 0; i < 3; i++) begin
         step(store(32'h20, 32'h5A5A5A5A), 1'b1);
         total++; if (bus.ADDR_ERROR !== 1'b0) begin bad++;
            $display("FAIL stall_addr_error got=%b exp=0 cyc=%0d", bus.ADDR_ERROR, i); end
      end
      step(load(32'h20, 5'd4), 1'b0);
      step(bubble(), 1'b0);
      total++; if (bus.WB_READ_DATA !== 32'hA5A5A5A5) begin bad++;
         $display("FAIL stall_store got=%h exp=a5a5a5a5", bus.WB_READ_DATA); end
   endtask

   task automatic test_reset_mid();
      step(load(32'h10, 5'd7), 1'b0);
      step(op(1, 0, 1, 1, 0, 1, 0, 32'h10, 32'hBAD0BAD0, 32'h1234, 5'd7), 1'b0);
      RESET_N = 1'b0;
      #1;
      total++; if ({bus.PC_SRC, bus.WB_VALID, bus.WB_REG_WRITE, bus.WB_MEM_TO_REG, bus.ADDR_ERROR} !== 5'b0
                   || bus.PC_TARGET !== 32'h0 || bus.WB_READ_DATA !== 32'h0
                   || bus.WB_ALU_RESULT !== 32'h0 || bus.WB_WRITE_REGISTER !== 5'd0) begin
         bad++; $display("FAIL mid_reset_outputs got=%b/%h/%h/%h/%0d exp=0",
                         {bus.PC_SRC, bus.WB_VALID, bus.WB_REG_WRITE, bus.WB_MEM_TO_REG, bus.ADDR_ERROR},
                         bus.PC_TARGET, bus.WB_READ_DATA, bus.WB_ALU_RESULT, bus.WB_WRITE_REGISTER); end
      @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      model_reset();
      step(load(32'h10, 5'd7), 1'b0);
      step(bubble(), 1'b0);
      total++; if (bus.WB_READ_DATA !== 32'h11112222) begin bad++;
         $display("FAIL mid_reset_no_store got=%h exp=11112222", bus.WB_READ_DATA); end
   endtask

   task automatic test_back_to_back();
      ex_t e;
      logic [31:0] a;
      for (int k = 0; k < 8; k++) step(store(32'h100 + 4 * k, $urandom), 1'b0);
      for (int n = 0; n < 60; n++) begin
         a = 32'h100 + 4 * $urandom_range(0, 7);
         case ($urandom_range(0, 5))
            0: e = load(a, 5'($urandom));
            1: e = store(a, $urandom);
            2: e = op(1, 1, 1, 0, 1, 1, 0, a, $urandom, 32'h0, 5'($urandom));
            3: e = op(1, 0, 1, 0, 0, 1, 0, a + $urandom_range(1, 3), $urandom, 32'h0, 5'd1);
            4: e = op(1, 0, 0, 1, 0, 1, 1'($urandom), $urandom, 32'h0, $urandom, 5'd2);
            default: e = op(0, 1'($urandom), 1'($urandom), 0, 1, 1, 0, a, $urandom, 32'h0, 5'd3);
         endcase
         step(e, ($urandom_range(0, 5) == 0));
      end
      repeat (3) step(bubble(), 1'b0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_store_load();
      test_branch();
      test_misaligned();
      test_wrap();
      test_read_write();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "time limit");
   end

endmodule
